// File: rtl/fifo_rd_stream_pkg.sv
// Shared parameter helpers for the FIFO-read-port to valid/ready stream adapter.
package fifo_rd_stream_pkg;

  function automatic bit rd_latency_legal(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_skid_ring.sv
// Wrapping ring buffer with a registered head word; depth need not be a power of two.
module skid_ring
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  pop_i,
  input  logic                  clear_i,
  output logic [DATA_WIDTH-1:0] head_data_o
);

  localparam int PW = ptr_width(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [DATA_WIDTH-1:0] head_data_q, head_data_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (clear_i) begin
      head_d = '0;
      tail_d = '0;
    end else begin
      if (pop_i)  head_d = ptr_inc(head_q);
      if (push_i) tail_d = ptr_inc(tail_q);
    end
    // The word landing this edge may itself become the new head.
    head_data_d = mem_q[head_d];
    if (push_i && !clear_i && (head_d == tail_q)) head_data_d = wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      head_data_q <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      head_data_q <= head_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[tail_q] <= wdata_i;
  end

  assign head_data_o = head_data_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Prefetching adapter from a standard-mode fifo_sync read port to a valid/ready stream.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int SKID_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [DATA_WIDTH-1:0]              fifo_rd_data,
  output logic                               fifo_rd_en,
  input  logic                               fifo_empty,
  input  logic                               fifo_ready,
  input  logic                               flush,
  output logic [DATA_WIDTH-1:0]              rd_data,
  output logic                               rd_valid,
  input  logic                               rd_ready,
  output logic [level_width(SKID_DEPTH)-1:0] level
);

  localparam int LW  = level_width(SKID_DEPTH);
  localparam int IFW = $clog2(RD_LATENCY + 1);
  localparam int CW  = LW + 1;

  if (!rd_latency_legal(RD_LATENCY) || (SKID_DEPTH < RD_LATENCY + 1)) begin : g_bad_cfg
    $fatal(1, "fifo_rd_stream: illegal RD_LATENCY/SKID_DEPTH combination");
  end

  logic [LW-1:0]         occ_q, occ_d;
  logic [IFW-1:0]        inflight_q, inflight_d;
  logic [RD_LATENCY-1:0] tag_q, tag_d;
  logic [RD_LATENCY-1:0] issue_q, issue_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  credit_ok, issue, capture, pop;

  // Pops do not return credit in the same cycle; this keeps the check purely registered.
  assign credit_ok = ({1'b0, occ_q} + CW'(inflight_q)) < CW'(SKID_DEPTH);
  assign issue     = rst_n & fifo_ready & ~fifo_empty & ~flush & credit_ok;
  assign capture   = tag_q[RD_LATENCY-1] & ~flush;
  assign pop       = rd_valid_q & rd_ready;

  // issue_q retires every read for credit; tag_q is wiped by flush so stale data is dropped.
  always_comb begin
    issue_d    = RD_LATENCY'({issue_q, issue});
    tag_d      = flush ? '0 : RD_LATENCY'({tag_q, issue});
    inflight_d = inflight_q + IFW'(issue) - IFW'(issue_q[RD_LATENCY-1]);
    occ_d      = flush ? '0 : occ_q + LW'(capture) - LW'(pop);
    rd_valid_d = (occ_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q      <= '0;
      inflight_q <= '0;
      tag_q      <= '0;
      issue_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
      issue_q    <= issue_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  skid_ring #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (SKID_DEPTH)
  ) u_ring (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (capture),
    .wdata_i    (fifo_rd_data),
    .pop_i      (pop),
    .clear_i    (flush),
    .head_data_o(rd_data)
  );

  assign fifo_rd_en = issue;
  assign rd_valid   = rd_valid_q;
  assign level      = occ_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench: three adapters (L=1/D=4, L=2/D=4, L=2/D=6) each fed by a fifo_sync model.
module tb_fifo_rd_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] fifo_rd_data [3];
  logic       fifo_rd_en   [3];
  logic       fifo_empty   [3];
  logic       fifo_ready   [3];
  logic       flush_s      [3];
  logic [7:0] rd_data      [3];
  logic       rd_valid     [3];
  logic       rd_ready     [3];
  logic [2:0] level        [3];

  logic [7:0]  fmem [3][2048];
  logic [10:0] wp   [3];
  logic [10:0] rp   [3] = '{default: '0};
  logic [7:0]  dq1  [3];
  logic [7:0]  rxq  [3][$];
  logic [7:0]  expq [$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic int lat(input int l);
    return (l == 0) ? 1 : 2;
  endfunction

  function automatic int dep(input int l);
    return (l == 2) ? 6 : 4;
  endfunction

  for (genvar i = 0; i < 3; i++) begin : gen_lane
    localparam int L = (i == 0) ? 1 : 2;
    localparam int D = (i == 2) ? 6 : 4;

    fifo_rd_stream #(.DATA_WIDTH(8), .RD_LATENCY(L), .SKID_DEPTH(D)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .fifo_rd_data(fifo_rd_data[i]),
      .fifo_rd_en  (fifo_rd_en[i]),
      .fifo_empty  (fifo_empty[i]),
      .fifo_ready  (fifo_ready[i]),
      .flush       (flush_s[i]),
      .rd_data     (rd_data[i]),
      .rd_valid    (rd_valid[i]),
      .rd_ready    (rd_ready[i]),
      .level       (level[i])
    );

    assign fifo_empty[i] = (wp[i] == rp[i]);

    always @(posedge clk) begin
      if (rst_n) begin
        total++;
        assert (int'(u_dut.occ_q) + int'(u_dut.inflight_q) <= D) else begin
          bad++;
          $error("FAIL credit lane=%0d observed=%0d expected<=%0d", i,
                 int'(u_dut.occ_q) + int'(u_dut.inflight_q), D);
        end
        if (u_dut.capture) begin
          total++;
          assert (int'(u_dut.occ_q) != D) else begin
            bad++;
            $error("FAIL full_capture lane=%0d observed=capture expected=none", i);
          end
        end
      end
    end
  end

  // fifo_sync model: one output register for latency 1, an extra DO_REG stage for latency 2.
  always @(posedge clk) begin
    for (int l = 0; l < 3; l++) begin
      if (fifo_rd_en[l]) begin
        rp[l]  <= rp[l] + 11'd1;
        dq1[l] <= fmem[l][rp[l]];
      end
      if (lat(l) == 1) begin
        if (fifo_rd_en[l]) fifo_rd_data[l] <= fmem[l][rp[l]];
      end else begin
        fifo_rd_data[l] <= dq1[l];
      end
    end
  end

  always @(posedge clk) begin
    for (int l = 0; l < 3; l++) begin
      if (rst_n && rd_valid[l] && rd_ready[l]) rxq[l].push_back(rd_data[l]);
      if (fifo_rd_en[l]) begin
        total++;
        assert (wp[l] != rp[l]) else begin
          bad++;
          $error("FAIL underflow lane=%0d observed=rd_en_on_empty expected=no_read", l);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic put(input int l, input logic [7:0] v);
    fmem[l][wp[l]] = v;
    wp[l] = wp[l] + 11'd1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [10:0] rp0 [3];
    int          npre [3];
    int          rem  [3];
    int          mism;
    int          found;
    logic [7:0]  b;
    bit          ev;

    rst_n = 1'b0;
    for (int l = 0; l < 3; l++) begin
      fifo_ready[l] = 1'b0;
      flush_s[l]    = 1'b0;
      rd_ready[l]   = 1'b0;
      wp[l]         = '0;
    end
    repeat (3) tick();
    for (int l = 0; l < 3; l++) begin
      chk("rst_valid", rd_valid[l], 0);
      chk("rst_level", level[l], 0);
      chk("rst_data", rd_data[l], 0);
      chk("rst_rd_en", fifo_rd_en[l], 0);
    end
    rst_n = 1'b1;
    for (int l = 0; l < 3; l++) begin
      fifo_ready[l] = 1'b1;
      rd_ready[l]   = 1'b1;
    end
    tick();

    // Streaming latency and full throughput.
    for (int l = 0; l < 3; l++)
      for (int k = 1; k <= 16; k++) put(l, 8'(k));
    #1;
    for (int l = 0; l < 3; l++) chk("t1_first_rd_en", fifo_rd_en[l], 1);
    for (int j = 1; j <= 20; j++) begin
      tick();
      for (int l = 0; l < 3; l++) begin
        ev = (j >= lat(l) + 1) && (j <= lat(l) + 16);
        chk("t1_valid", rd_valid[l], ev);
        if (ev) chk("t1_data", rd_data[l], j - lat(l));
      end
    end

    // Stalled consumer: prefetch fills the ring exactly, head word held.
    for (int l = 0; l < 3; l++) begin
      rd_ready[l] = 1'b0;
      rxq[l].delete();
      rp0[l] = rp[l];
      for (int k = 1; k <= 8; k++) put(l, 8'(k));
    end
    repeat (12) tick();
    for (int l = 0; l < 3; l++) begin
      chk("t2_level", level[l], dep(l));
      chk("t2_rd_en", fifo_rd_en[l], 0);
      chk("t2_reads", 11'(rp[l] - rp0[l]), dep(l));
      chk("t2_valid", rd_valid[l], 1);
    end
    repeat (3) begin
      tick();
      for (int l = 0; l < 3; l++) chk("t2_hold", rd_data[l], 8'h01);
    end
    for (int l = 0; l < 3; l++) rd_ready[l] = 1'b1;
    repeat (30) tick();
    for (int l = 0; l < 3; l++) begin
      chk("t2_count", rxq[l].size(), 8);
      for (int k = 0; k < 8 && k < rxq[l].size(); k++) chk("t2_order", rxq[l][k], k + 1);
    end

    // Random data under heavy backpressure.
    expq.delete();
    for (int l = 0; l < 3; l++) rxq[l].delete();
    for (int k = 0; k < 1024; k++) begin
      b = 8'($urandom_range(0, 255));
      expq.push_back(b);
      for (int l = 0; l < 3; l++) put(l, b);
    end
    for (int c = 0; c < 30000; c++) begin
      tick();
      for (int l = 0; l < 3; l++) rd_ready[l] = ($urandom_range(0, 9) == 0);
      if (rxq[0].size() >= 1024 && rxq[1].size() >= 1024 && rxq[2].size() >= 1024) break;
    end
    for (int l = 0; l < 3; l++) begin
      rd_ready[l] = 1'b0;
      chk("t3_count", rxq[l].size(), 1024);
      mism = 0;
      for (int k = 0; k < rxq[l].size() && k < 1024; k++)
        if (rxq[l][k] !== expq[k]) mism++;
      chk("t3_order", mism, 0);
    end
    tick();

    // Flush with three buffered words and two reads in flight (lane 2: L=2, D=6).
    rxq[2].delete();
    rp0[2] = rp[2];
    for (int k = 0; k < 10; k++) put(2, 8'h41 + 8'(k));
    repeat (5) tick();
    chk("t4_pre_level", level[2], 3);
    chk("t4_pre_reads", 11'(rp[2] - rp0[2]), 5);
    chk("t4_pre_rd_en", fifo_rd_en[2], 1);
    flush_s[2] = 1'b1;
    #1;
    chk("t4_flush_rd_en", fifo_rd_en[2], 0);
    tick();
    chk("t4_level", level[2], 0);
    chk("t4_valid", rd_valid[2], 0);
    flush_s[2]  = 1'b0;
    rd_ready[2] = 1'b1;
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      tick();
      if (rd_valid[2]) found = 1;
    end
    chk("t4_valid_seen", found, 1);
    chk("t4_first_word", rd_data[2], 8'h46);
    repeat (20) tick();
    chk("t4_count", rxq[2].size(), 5);
    for (int k = 0; k < 5 && k < rxq[2].size(); k++) chk("t4_order", rxq[2][k], 8'h46 + 8'(k));
    chk("t4_reads", 11'(rp[2] - rp0[2]), 10);

    // Handshake and flush on the same edge (lane 1: L=2, D=4).
    rxq[1].delete();
    for (int k = 0; k < 6; k++) put(1, 8'h51 + 8'(k));
    repeat (10) tick();
    chk("t5_pre_level", level[1], 4);
    chk("t5_pre_data", rd_data[1], 8'h51);
    rd_ready[1] = 1'b1;
    flush_s[1]  = 1'b1;
    tick();
    chk("t5_level", level[1], 0);
    chk("t5_valid", rd_valid[1], 0);
    chk("t5_delivered", rxq[1].size(), 1);
    if (rxq[1].size() > 0) chk("t5_head_word", rxq[1][0], 8'h51);
    flush_s[1] = 1'b0;
    repeat (15) tick();
    chk("t5_count", rxq[1].size(), 3);
    if (rxq[1].size() >= 3) begin
      chk("t5_next0", rxq[1][1], 8'h55);
      chk("t5_next1", rxq[1][2], 8'h56);
    end

    // Asynchronous reset mid-stream, then resume from remaining FIFO contents.
    for (int l = 0; l < 3; l++) begin
      rxq[l].delete();
      rd_ready[l] = 1'b1;
      for (int k = 0; k < 12; k++) put(l, 8'h61 + 8'(k));
    end
    repeat (4) tick();
    for (int l = 0; l < 3; l++) chk("t6_pre_valid", rd_valid[l], 1);
    #2;
    rst_n = 1'b0;
    #1;
    for (int l = 0; l < 3; l++) begin
      chk("t6_rst_valid", rd_valid[l], 0);
      chk("t6_rst_level", level[l], 0);
      chk("t6_rst_rd_en", fifo_rd_en[l], 0);
      chk("t6_rst_data", rd_data[l], 0);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int l = 0; l < 3; l++) begin
      npre[l] = rxq[l].size();
      rem[l]  = int'(11'(wp[l] - rp[l]));
      rp0[l]  = rp[l];
    end
    repeat (30) tick();
    for (int l = 0; l < 3; l++) begin
      chk("t6_count", rxq[l].size(), npre[l] + rem[l]);
      mism = 0;
      for (int k = 0; k < rxq[l].size(); k++) begin
        if (k < npre[l]) begin
          if (rxq[l][k] !== 8'h61 + 8'(k)) mism++;
        end else if (rxq[l][k] !== fmem[l][11'(rp0[l] + 11'(k - npre[l]))]) begin
          mism++;
        end
      end
      chk("t6_order", mism, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
